// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path (and the future transmitter).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   localparam int unsigned OVERSAMPLE = 16;

   // Clocks per oversampling tick, rounded to nearest; never returns 0.
   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      int unsigned d;
      d = (clk_hz + baud * 8) / (baud * 16);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversampling tick generator: one-cycle tick every DIV clocks, restartable by clear.
module baud_tick_gen #(
   parameter int unsigned DIV = 27
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned DIV_I = (DIV == 0) ? 1 : DIV;
   localparam int unsigned W     = (DIV_I > 1) ? $clog2(DIV_I) : 1;
   localparam logic [W-1:0] LAST = W'(DIV_I - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset || clear)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, 16x oversampling, mid-bit sampling, framing-error detection.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned DIV       = calc_div(CLK_HZ, BAUD);
   localparam logic [3:0]  LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]  MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

   logic       sync1, rxs;
   logic       tick, clear;
   state_t     state, state_n;
   logic [3:0] tick_cnt, tick_cnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] sr, sr_n, data_n;
   logic       valid_n, frame_err_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   baud_tick_gen #(.DIV(DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .tick  (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         sr        <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_cnt_n;
         bit_idx   <= bit_idx_n;
         sr        <= sr_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= frame_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      tick_cnt_n  = tick ? tick_cnt + 4'd1 : tick_cnt;
      bit_idx_n   = bit_idx;
      sr_n        = sr;
      data_n      = data;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;
      clear       = 1'b0;
      case (state)
         IDLE: begin
            tick_cnt_n = '0;
            if (!rxs) begin
               clear   = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (tick && tick_cnt == MID_TICK) begin
               tick_cnt_n = '0;
               bit_idx_n  = '0;
               state_n    = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            // tick_cnt wraps 15->0 on its own between data bits
            if (tick && tick_cnt == LAST_TICK) begin
               sr_n      = {rxs, sr[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  tick_cnt_n = '0;
                  state_n    = STOP;
               end
            end
         end
         STOP: begin
            if (tick && tick_cnt == LAST_TICK) begin
               tick_cnt_n = '0;
               if (rxs) begin
                  data_n  = sr;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = BREAK;
               end
            end
         end
         BREAK: begin
            if (rxs) begin
               tick_cnt_n = '0;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames from a behavioural transmitter, results against an expected-byte queue.
module tb_uart_rx;

   localparam int BIT_A = 432;   // 16 ticks * 27 clocks at 50 MHz / 115200
   localparam int BIT_B = 16;    // DIV = 1 instance

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rxd_a = 1'b1, rxd_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, frame_err_a, frame_err_b, busy_a, busy_b;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int vcyc_b   = 0;
   int start_cyc = 0;
   int fe_cnt_a = 0, fe_cnt_b = 0, both_cnt = 0;
   bit busy_seen_a = 0;

   logic [7:0] obs_a[$], exp_a[$], obs_b[$];

   uart_rx #(.CLK_HZ(50000000), .BAUD(115200), .OVERSAMPLE(16)) dut_a (
      .clock(clock), .reset(reset), .rxd(rxd_a),
      .data(data_a), .valid(valid_a), .frame_err(frame_err_a), .busy(busy_a)
   );

   uart_rx #(.CLK_HZ(1600), .BAUD(100), .OVERSAMPLE(16)) dut_b (
      .clock(clock), .reset(reset), .rxd(rxd_b),
      .data(data_b), .valid(valid_b), .frame_err(frame_err_b), .busy(busy_b)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (valid_a) obs_a.push_back(data_a);
      if (valid_b) begin
         obs_b.push_back(data_b);
         vcyc_b = cyc;
      end
      if (frame_err_a) fe_cnt_a++;
      if (frame_err_b) fe_cnt_b++;
      if ((valid_a && frame_err_a) || (valid_b && frame_err_b)) both_cnt++;
      if (busy_a) busy_seen_a = 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic drive_bit(input int inst, input logic v, input int n);
      if (inst == 0) rxd_a = v; else rxd_b = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_frame(input int inst, input logic [7:0] b, input int n, input logic stop_bit);
      start_cyc = cyc;
      drive_bit(inst, 1'b0, n);
      for (int i = 0; i < 8; i++) drive_bit(inst, b[i], n);
      drive_bit(inst, stop_bit, n);
   endtask

   task automatic idle_a(input int n);
      rxd_a = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   // Receiver A must have produced exactly the expected bytes so far.
   task automatic check_rx_a(input string tag);
      chk({tag, "_count"}, obs_a.size(), exp_a.size());
      if (exp_a.size() > 0 && obs_a.size() > 0)
         chk({tag, "_data"}, obs_a[obs_a.size()-1], exp_a[exp_a.size()-1]);
   endtask

   initial begin
      logic [7:0] b;
      int fe0, nv0;
      logic [7:0] d0;

      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset_data",  data_a, 8'h00);
      chk("reset_valid", valid_a, 1'b0);
      chk("reset_ferr",  frame_err_a, 1'b0);
      chk("reset_busy",  busy_a, 1'b0);
      chk("reset_data_b", data_b, 8'h00);
      repeat (20) @(negedge clock);

      // DIV=1 instance: all-zero and all-one bytes, latency from start edge
      send_frame(1, 8'h00, BIT_B, 1'b1);
      chk("b00_count", obs_b.size(), 1);
      chk("b00_data", data_b, 8'h00);
      chk("b00_latency", (vcyc_b - start_cyc >= 152) && (vcyc_b - start_cyc <= 156), 1);
      send_frame(1, 8'hFF, BIT_B, 1'b1);
      chk("bFF_count", obs_b.size(), 2);
      chk("bFF_data", data_b, 8'hFF);
      chk("bFF_latency", (vcyc_b - start_cyc >= 152) && (vcyc_b - start_cyc <= 156), 1);
      chk("b_no_ferr", fe_cnt_b, 0);
      repeat (40) @(negedge clock);

      // Back-to-back 0x55 then 0xA3, no idle gap
      exp_a.push_back(8'h55);
      send_frame(0, 8'h55, BIT_A, 1'b1);
      chk("f55_busy_after_stop", busy_a, 1'b0);
      exp_a.push_back(8'hA3);
      send_frame(0, 8'hA3, BIT_A, 1'b1);
      chk("fA3_busy_after_stop", busy_a, 1'b0);
      check_rx_a("b2b");
      chk("b2b_first", obs_a[0], 8'h55);
      chk("b2b_ferr", fe_cnt_a, 0);

      for (int k = 0; k < 3; k++) begin
         b = 8'($urandom_range(0, 255));
         exp_a.push_back(b);
         send_frame(0, b, BIT_A, 1'b1);
         check_rx_a("rand");
         idle_a($urandom_range(0, 300));
      end

      // 5-tick low glitch is a false start
      idle_a(BIT_A);
      nv0 = obs_a.size();
      fe0 = fe_cnt_a;
      busy_seen_a = 0;
      rxd_a = 1'b0;
      repeat (5 * 27) @(negedge clock);
      rxd_a = 1'b1;
      repeat (9 * 27 - 5 * 27) @(negedge clock);
      chk("glitch_busy_seen", busy_seen_a, 1'b1);
      chk("glitch_idle_by_tick9", busy_a, 1'b0);
      idle_a(2 * BIT_A);
      chk("glitch_no_valid", obs_a.size(), nv0);
      chk("glitch_no_ferr", fe_cnt_a, fe0);

      // Stop bit low, line held low 3 more bit times, then released
      d0 = data_a;
      send_frame(0, 8'h3C, BIT_A, 1'b0);
      repeat (3 * BIT_A) @(negedge clock);
      chk("brk_busy_held", busy_a, 1'b1);
      idle_a(2 * BIT_A);
      chk("brk_ferr_once", fe_cnt_a, fe0 + 1);
      chk("brk_no_valid", obs_a.size(), nv0);
      chk("brk_data_kept", data_a, d0);
      chk("brk_idle", busy_a, 1'b0);

      // Transmitter off by -3% and +3% in bit period
      exp_a.push_back(8'hC5);
      send_frame(0, 8'hC5, 445, 1'b1);
      check_rx_a("slow3");
      idle_a(100);
      exp_a.push_back(8'hC5);
      send_frame(0, 8'hC5, 419, 1'b1);
      check_rx_a("fast3");
      idle_a(BIT_A);

      // Reset pulse in the middle of data bit 4 of 0x96
      nv0 = obs_a.size();
      fe0 = fe_cnt_a;
      b = 8'h96;
      drive_bit(0, 1'b0, BIT_A);
      for (int i = 0; i < 4; i++) drive_bit(0, b[i], BIT_A);
      drive_bit(0, b[4], BIT_A / 2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      rxd_a = 1'b1;
      @(negedge clock);
      chk("abort_data_reset", data_a, 8'h00);
      chk("abort_busy", busy_a, 1'b0);
      idle_a(2 * BIT_A);
      chk("abort_no_valid", obs_a.size(), nv0);
      chk("abort_no_ferr", fe_cnt_a, fe0);
      exp_a.push_back(8'h12);
      send_frame(0, 8'h12, BIT_A, 1'b1);
      check_rx_a("after_abort");
      idle_a(BIT_A);

      chk("total_count", obs_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++)
         chk("seq", obs_a[i], exp_a[i]);
      chk("total_ferr", fe_cnt_a, 1);
      chk("valid_ferr_exclusive", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
